// File: rtl/krnl_vadd_rtl_result_packer.sv
// Result packer for the vadd write path.
// Gathers RATIO narrow sum words into one wide AXI4-Stream beat, frames a run of
// ctrl_length words (partial last beat with tkeep, tlast on the final beat) and
// pulses ctrl_done when the final beat has left. A pack register and an output
// register give one beat of slack, so a full-rate input is sustained while
// m_tready stays high.
module krnl_vadd_rtl_result_packer #(
    parameter int C_S_DATA_WIDTH = 32,
    parameter int C_M_DATA_WIDTH = 128,
    parameter int C_LENGTH_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        areset_n,
    input  logic                        ctrl_start,
    input  logic [C_LENGTH_WIDTH-1:0]   ctrl_length,
    output logic                        ctrl_done,
    input  logic                        s_tvalid,
    input  logic [C_S_DATA_WIDTH-1:0]   s_tdata,
    output logic                        s_tready,
    output logic                        m_tvalid,
    output logic [C_M_DATA_WIDTH-1:0]   m_tdata,
    output logic [C_M_DATA_WIDTH/8-1:0] m_tkeep,
    output logic                        m_tlast,
    input  logic                        m_tready
);
    localparam int RATIO  = C_M_DATA_WIDTH / C_S_DATA_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BPW    = C_S_DATA_WIDTH / 8;
    localparam int KEEP_W = C_M_DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DONE} state_t;

    state_t                                 state;
    logic [C_LENGTH_WIDTH-1:0]              remaining;
    logic [LANE_W-1:0]                      lane_idx;

    // Pack register: lanes filled so far, or a whole completed beat waiting
    // for the output register (pack_pend=1).
    logic [RATIO-1:0][C_S_DATA_WIDTH-1:0]   pack_data;
    logic [KEEP_W-1:0]                      pack_keep;
    logic                                   pack_last;
    logic                                   pack_pend;

    logic                                   out_free;
    logic                                   accept;
    logic                                   final_word;
    logic                                   beat_done;
    logic                                   move_pend;
    logic                                   load_new;
    logic [RATIO-1:0][C_S_DATA_WIDTH-1:0]   beat_data;
    logic [KEEP_W-1:0]                      beat_keep;

    // Output register can take a beat this edge if empty or draining now.
    assign out_free   = !m_tvalid || m_tready;
    // Stall input only when a completed beat is parked and cannot move on.
    assign s_tready   = (state == S_PACK) && (remaining != '0) && !(pack_pend && !out_free);
    assign accept     = s_tvalid && s_tready;
    assign final_word = (remaining == C_LENGTH_WIDTH'(1));
    assign beat_done  = accept && ((lane_idx == LANE_W'(RATIO - 1)) || final_word);
    assign move_pend  = pack_pend && out_free;
    assign load_new   = beat_done && out_free && !pack_pend;

    // Beat as it looks after merging the incoming word; a parked beat is
    // leaving this cycle whenever a word is accepted, so start from empty lanes.
    always_comb begin
        beat_data           = pack_pend ? '0 : pack_data;
        beat_data[lane_idx] = s_tdata;
        beat_keep           = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (LANE_W'(l) <= lane_idx)
                beat_keep[l*BPW +: BPW] = '1;
        end
    end

    // Run control: state, word countdown, lane pointer and the done pulse.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            lane_idx  <= '0;
            ctrl_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ctrl_done <= 1'b0;
                    if (ctrl_start) begin
                        remaining <= ctrl_length;
                        lane_idx  <= '0;
                        if (ctrl_length != '0) begin
                            state <= S_PACK;
                        end else begin
                            state     <= S_DONE;
                            ctrl_done <= 1'b1;
                        end
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        lane_idx  <= beat_done ? '0 : lane_idx + 1'b1;
                    end
                    if (m_tvalid && m_tready && m_tlast) begin
                        state     <= S_DONE;
                        ctrl_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    ctrl_done <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    ctrl_done <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: fill the pack register, hand completed beats to the output register.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pack_data <= '0;
            pack_keep <= '0;
            pack_last <= 1'b0;
            pack_pend <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
        end else begin
            if (move_pend) begin
                m_tvalid <= 1'b1;
                m_tdata  <= pack_data;
                m_tkeep  <= pack_keep;
                m_tlast  <= pack_last;
            end else if (load_new) begin
                m_tvalid <= 1'b1;
                m_tdata  <= beat_data;
                m_tkeep  <= beat_keep;
                m_tlast  <= final_word;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            if (accept) begin
                if (beat_done && !load_new) begin
                    pack_data <= beat_data;
                    pack_keep <= beat_keep;
                    pack_last <= final_word;
                    pack_pend <= 1'b1;
                end else if (beat_done) begin
                    pack_data <= '0;
                    pack_pend <= 1'b0;
                end else begin
                    pack_data <= beat_data;
                    pack_pend <= 1'b0;
                end
            end else if (move_pend) begin
                pack_data <= '0;
                pack_pend <= 1'b0;
            end
        end
    end

endmodule
